handshake_cmpi_pipe: RTL

HANDSHAKE_CMPI_PIPE -- requirements
Module: handshake_cmpi_pipe

---
 rtl/handshake_pkg.sv | 50 +++++
 rtl/elastic_stage.sv | 42 ++++
 rtl/join_type.sv | 15 +
 rtl/handshake_cmpi_pipe.sv | 100 ++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - predicate codes and the 1-bit integer compare used by the cmpi pipeline
package handshake_pkg;

  typedef enum logic [3:0] {
    PRED_EQ  = 4'd0,
    PRED_NE  = 4'd1,
    PRED_SLT = 4'd2,
    PRED_SLE = 4'd3,
    PRED_SGT = 4'd4,
    PRED_SGE = 4'd5,
    PRED_ULT = 4'd6,
    PRED_ULE = 4'd7,
    PRED_UGT = 4'd8,
    PRED_UGE = 4'd9
  } cmpi_pred_e;

  localparam int CMPI_PRED_MAX    = 9;
  localparam int CMPI_WIDTH_MAX   = 64;
  localparam int CMPI_LATENCY_MAX = 4;

  function automatic logic pred_is_signed(input cmpi_pred_e pred);
    return (pred == PRED_SLT) || (pred == PRED_SLE) ||
           (pred == PRED_SGT) || (pred == PRED_SGE);
  endfunction

  // Operands arrive already widened to 64 bits: sign-extended for signed codes,
  // zero-extended otherwise, so eq/ne stay bitwise either way.
  function automatic logic cmpi_eval(input cmpi_pred_e pred,
                                     input logic [63:0] lhs_x,
                                     input logic [63:0] rhs_x);
    logic signed [63:0] lhs_s;
    logic signed [63:0] rhs_s;
    lhs_s = signed'(lhs_x);
    rhs_s = signed'(rhs_x);
    case (pred)
      PRED_EQ:  return lhs_x == rhs_x;
      PRED_NE:  return lhs_x != rhs_x;
      PRED_SLT: return lhs_s <  rhs_s;
      PRED_SLE: return lhs_s <= rhs_s;
      PRED_SGT: return lhs_s >  rhs_s;
      PRED_SGE: return lhs_s >= rhs_s;
      PRED_ULT: return lhs_x <  rhs_x;
      PRED_ULE: return lhs_x <= rhs_x;
      PRED_UGT: return lhs_x >  rhs_x;
      PRED_UGE: return lhs_x >= rhs_x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// rtl/elastic_stage.sv - one-entry elastic register for a 1-bit payload with combinational ready
module elastic_stage (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready
);

  logic full_q;
  logic full_d;
  logic data_q;
  logic data_d;

  // Ready looks through to downstream so a full pipe still moves every cycle.
  assign in_ready  = ~full_q | out_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_ready) begin
      full_d = in_valid;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/join_type.sv
// rtl/join_type.sv - two-input valid/ready join; neither side is consumed alone
module join_type (
  input  logic a_valid,
  output logic a_ready,
  input  logic b_valid,
  output logic b_ready,
  output logic out_valid,
  input  logic out_ready
);

  assign out_valid = a_valid & b_valid;
  assign a_ready   = b_valid & out_ready;
  assign b_ready   = a_valid & out_ready;

endmodule

// File: rtl/handshake_cmpi_pipe.sv
// rtl/handshake_cmpi_pipe.sv - joined-operand integer compare with a LATENCY-deep elastic result pipe
module handshake_cmpi_pipe
  import handshake_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int PREDICATE = 2,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  output logic                 lhs_ready,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  output logic                 rhs_ready,
  output logic                 result,
  output logic                 result_valid,
  input  logic                 result_ready
);

  if (PREDICATE < 0 || PREDICATE > CMPI_PRED_MAX) begin : g_bad_predicate
    $error("handshake_cmpi_pipe: PREDICATE %0d outside 0..%0d", PREDICATE, CMPI_PRED_MAX);
  end
  if (LATENCY < 1 || LATENCY > CMPI_LATENCY_MAX) begin : g_bad_latency
    $error("handshake_cmpi_pipe: LATENCY %0d outside 1..%0d", LATENCY, CMPI_LATENCY_MAX);
  end
  if (DATA_TYPE < 1 || DATA_TYPE > CMPI_WIDTH_MAX) begin : g_bad_width
    $error("handshake_cmpi_pipe: DATA_TYPE %0d outside 1..%0d", DATA_TYPE, CMPI_WIDTH_MAX);
  end

  localparam logic [3:0] PRED_CODE = PREDICATE[3:0];
  localparam cmpi_pred_e PRED      = cmpi_pred_e'(PRED_CODE);

  logic [63:0] lhs_x;
  logic [63:0] rhs_x;
  logic        cmp;
  logic        join_valid;
  logic        stage0_ready;

  always_comb begin
    if (pred_is_signed(PRED)) begin
      lhs_x = 64'($signed(lhs));
      rhs_x = 64'($signed(rhs));
    end else begin
      lhs_x = 64'(lhs);
      rhs_x = 64'(rhs);
    end
    cmp = cmpi_eval(PRED, lhs_x, rhs_x);
  end

  join_type u_join (
    .a_valid   (lhs_valid),
    .a_ready   (lhs_ready),
    .b_valid   (rhs_valid),
    .b_ready   (rhs_ready),
    .out_valid (join_valid),
    .out_ready (stage0_ready)
  );

  // Per-stage scalars keep the ready chain free of self-referencing vectors.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_ready;

    if (k == 0) begin : g_head
      assign in_valid = join_valid;
      assign in_data  = cmp;
    end else begin : g_link
      assign in_valid = g_stage[k-1].out_valid;
      assign in_data  = g_stage[k-1].out_data;
    end

    if (k == LATENCY - 1) begin : g_tail
      assign out_ready = result_ready;
    end else begin : g_mid
      assign out_ready = g_stage[k+1].in_ready;
    end

    elastic_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
    );
  end

  assign stage0_ready = g_stage[0].in_ready;
  assign result_valid = g_stage[LATENCY-1].out_valid;
  assign result       = g_stage[LATENCY-1].out_data;

endmodule
